// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped read cache with multi-beat line refill and hit/access counters
module dm_cache_ctrl #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  access_cnt,
    output logic              busy
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OFFSET_W-1:0] beat_q, beat_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    access_cnt_q, access_cnt_d;

    logic [TAG_W-1:0]  tag_array  [LINES];
    logic [DATA_W-1:0] data_array [LINES << OFFSET_W];

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                lookup_hit;
    logic                beat_fire;

    assign tag        = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
    assign index      = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign offset     = addr_q[OFFSET_W-1:0];
    assign lookup_hit = valid_q[index] && (tag_array[index] == tag);
    assign beat_fire  = (state_q == REFILL) && mem_valid;

    assign req_ready  = (state_q == IDLE) && !flush && !rst;
    assign rsp_valid  = (state_q == RESPOND);
    assign busy       = (state_q != IDLE);
    assign rsp_data   = rsp_data_q;
    assign rsp_hit    = rsp_hit_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign hit_cnt    = hit_cnt_q;
    assign access_cnt = access_cnt_q;

    // Next-state and next-output computation for the lookup/refill controller
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        valid_d      = valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_hit_d    = rsp_hit_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        hit_cnt_d    = hit_cnt_q;
        access_cnt_d = access_cnt_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    rsp_data_d = data_array[{index, offset}];
                    rsp_hit_d  = 1'b1;
                    state_d    = RESPOND;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    beat_d     = '0;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    rsp_data_d = (beat_q == offset) ? mem_data : rsp_data_q;
                    beat_d     = beat_q + 1'b1;
                    if (&beat_q) begin
                        valid_d[index] = 1'b1;
                        mem_req_d      = 1'b0;
                        rsp_hit_d      = 1'b0;
                        state_d        = RESPOND;
                    end
                end
            end
            RESPOND: begin
                access_cnt_d = access_cnt_q + {{(CNT_W-1){1'b0}}, ~&access_cnt_q};
                hit_cnt_d    = hit_cnt_q + {{(CNT_W-1){1'b0}}, rsp_hit_q & ~&hit_cnt_q};
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state, valid bits, response and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            valid_q      <= '0;
            rsp_data_q   <= '0;
            rsp_hit_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt_q    <= '0;
            access_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            valid_q      <= valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_hit_q    <= rsp_hit_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            access_cnt_q <= access_cnt_d;
        end
    end

    // Tag and data arrays are not reset; the valid bits guard their contents
    always_ff @(posedge clk) begin
        if (!rst && beat_fire) begin
            data_array[{index, beat_q}] <= mem_data;
            if (&beat_q) tag_array[index] <= tag;
        end
    end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Clocked, parametrised direct-mapped read cache that sits between a word-addressed requester and a backing memory. It performs tag lookup on accepted requests. On a miss it runs a multi-beat line refill over a valid/data memory handshake, then returns the requested word. Hit and access counters are kept for performance monitoring. A flush input invalidates all lines in one cycle.

Parameters:
ADDR_W, 15, word-address width
DATA_W, 32, word width
INDEX_W, 10, line-index bits (2^INDEX_W lines)
OFFSET_W, 2, word-in-line bits (2^OFFSET_W words per line)
CNT_W, 16, width of hit/access counters
Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W; must be >=1 (3 at defaults).

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  requester has a read request
req_addr  in  ADDR_W  word address
req_ready  out  1  request accepted this cycle when req_valid&req_ready
flush  in  1  invalidate all lines
rsp_valid  out  1  one-cycle pulse, response valid
rsp_data  out  DATA_W  read word
rsp_hit  out  1  1=served from cache, 0=served by refill
mem_req  out  1  refill request, level held for whole refill
mem_addr  out  ADDR_W  line base address {tag,index,OFFSET_W'b0}
mem_valid  in  1  one refill beat present
mem_data  in  DATA_W  refill beat data, beats in ascending offset order
hit_cnt  out  CNT_W  saturating hit count
access_cnt  out  CNT_W  saturating completed-access count
busy  out  1  state != IDLE

Behaviour:
- Storage: valid bit per line in a flop vector; tag array 2^INDEX_W x TAG_W; data array 2^(INDEX_W+OFFSET_W) x DATA_W. Address split is tag=addr[ADDR_W-1:INDEX_W+OFFSET_W], index=next INDEX_W bits, offset=addr[OFFSET_W-1:0].
- Reset: state IDLE; all valid bits 0. Outputs rsp_valid, rsp_data, rsp_hit, mem_req, mem_addr, hit_cnt, access_cnt and busy are all 0. req_ready is 0 while rst is high. Tag and data arrays are not cleared.
- req_ready = (state==IDLE) & !flush & !rst, combinational.
- IDLE: if flush, clear all valid bits next edge and stay IDLE. Flush has priority over req_valid in the same cycle; the request is not accepted. Else on req_valid&req_ready, latch req_addr and go LOOKUP. flush outside IDLE is ignored.
- LOOKUP (1 cycle): hit = valid[index] & (tag_array[index]==tag).
  - Hit: capture data_array[{index,offset}] into rsp_data, rsp_hit<=1, go RESPOND.
  - Miss: mem_req<=1, mem_addr<=line base, beat counter<=0, go REFILL.
- REFILL: on each mem_valid, write mem_data to data_array[{index,beat}]. If beat==offset, capture it into rsp_data. Increment beat. On the last beat (beat==2^OFFSET_W-1), write tag, set valid[index], mem_req<=0, rsp_hit<=0, go RESPOND. Gaps between beats are allowed, and there is no timeout.
- RESPOND (1 cycle): rsp_valid=1. access_cnt+1; hit_cnt+1 if rsp_hit. Both counters saturate at all-ones. Go IDLE.
- rsp_valid has no back-pressure. rsp_data and rsp_hit hold their value until the next response.
- Latency from the accept edge: hit gives rsp_valid 2 cycles later. Miss gives mem_req 2 cycles later and rsp_valid 1 cycle after the last beat.
- mem_valid outside REFILL is ignored; no array writes and no state change.
- Reset mid-refill: the next edge gives IDLE, mem_req=0, all lines invalid, and no response for the aborted request. Late beats are ignored.
- Back-to-back: a new request can be accepted the cycle after RESPOND. Each refill replaces the whole line.

Test Plan:
- Cold miss: after reset, request 15'h1234 (tag 1, index 0x08D, offset 0). Response: mem_req at T+2 with mem_addr 15'h1234. Feed beats A0,A1,A2,A3. Required: rsp_valid 1 cycle after A3, rsp_data=A0, rsp_hit=0, access_cnt=1, hit_cnt=0.
- Hit same line: request 15'h1236 -> rsp_valid at T+2, rsp_data=A2, rsp_hit=1, mem_req stays 0, hit_cnt=1.
- Conflict eviction: request 15'h2234 (tag 2, same index) -> miss with mem_addr 15'h2234 and beats B0..B3. Then 15'h1234 misses again, mem_addr 15'h1234.
- Gapped beats and stray beats: insert 3 idle cycles between beats, and pulse mem_valid while IDLE. Required: correct data and no corruption of cached lines.
- Flush: flush and req_valid both high in IDLE. Required: req_ready=0, request not taken. Next request 15'h1236 misses.
- Reset mid-refill: assert rst after 2 beats. Required: mem_req=0 and busy=0 next cycle, counters 0, no rsp_valid. Re-request of the same address misses. With CNT_W=2, 5 hits give hit_cnt=3.
